logicnet_stream_shell: RTL
==========================

// Module: logicnet_stream_shell
// PURPOSE
//  Streaming wrapper around a fixed-latency pipelined LogicNet (free-running pipeline registers, no enable).
//  Assembles BEAT_W-bit input beats into an IN_W-bit feature vector and drives it onto the network input.
//  Tracks each issued frame through the LATENCY-deep network with a tag shift register.
//  Captures each result into an output FIFO, with valid/ready on both sides; credit-limits issue so results never drop.
// PARAMETERS
//  BEAT_W      64   input beat width; IN_W % BEAT_W == 0
//  IN_W        512  network input width; BEATS = IN_W/BEAT_W >= 2
//  OUT_W       2    network output (class) width
//  LATENCY     4    clock cycles from net_in to matching net_out (network register stages), >= 1
//  FIFO_DEPTH  8    result FIFO entries, power of 2, >= 2
//  ERRC_W      16   frame-error counter width
// PORTS
//  clk       in   1       clock, all logic on rising edge
//  rst       in   1       synchronous reset, active-high
//  s_valid   in   1       input beat valid
//  s_ready   out  1       input beat accepted when s_valid & s_ready
//  s_data    in   BEAT_W  beat payload; beat k -> net_in[k*BEAT_W +: BEAT_W]
//  s_last    in   1       marks final beat of a frame
//  net_in    out  IN_W    feature vector to network (registered)
//  net_out   in   OUT_W   network result
//  m_valid   out  1       result FIFO non-empty
//  m_ready   in   1       result pop when m_valid & m_ready
//  m_data    out  OUT_W   FIFO head (first-word fall-through)
//  err_cnt   out  ERRC_W  saturating count of malformed frames
//  occupancy out  clog2(FIFO_DEPTH)+1  in-flight frames + FIFO entries
// BEHAVIOUR
//  Reset (rst=1 at an edge): beat_cnt=0, state=FILL, net_in=0, tags=0, FIFO empty, occupancy=0, err_cnt=0.
//   s_ready=0 and m_valid=0 while rst is high.
//  FSM states:
//   FILL: each accepted beat is written into net_in at slot beat_cnt.
//    - beat_cnt<BEATS-1, s_last=0: beat_cnt++.
//    - beat_cnt<BEATS-1, s_last=1 (short frame): err_cnt++, beat_cnt=0, no issue.
//    - beat_cnt==BEATS-1, s_last=1: beat_cnt=0, tag[0]=1 next cycle (issue).
//    - beat_cnt==BEATS-1, s_last=0 (long frame): err_cnt++, beat_cnt=0, no issue, go to DROP.
//   DROP: s_ready=1; beats discarded, net_in untouched; s_last beat returns to FILL.
//  Credit: s_ready in FILL = !(beat_cnt==BEATS-1 && occupancy>=FIFO_DEPTH).
//   Stall only on the final beat; a same-cycle pop is ignored (conservative).
//  Issue: the cycle after final-beat accept, net_in holds the complete frame and tag[0]=1.
//   tag shifts one stage per cycle. When tag[LATENCY-1] shifted out is 1, net_out is sampled into FIFO at that edge.
//   m_valid therefore rises LATENCY+1 cycles after the final-beat accept edge.
//   Non-issue cycles carry tag 0; net_out is ignored.
//  Back-to-back: a new frame may fill while earlier frames are in flight.
//   net_in changes only on beat writes; frames need >= BEATS cycles each, so tags never collide.
//  occupancy: +1 on issue, -1 on pop; simultaneous issue and pop leave it unchanged.
//   Bounded by FIFO_DEPTH, so the FIFO never overflows.
//   FIFO write when full is an internal assertion failure.
//  m_data is stable while m_valid=1 and m_ready=0. FIFO pointers wrap modulo FIFO_DEPTH.
//  err_cnt saturates at all-ones. Counts within one cycle are mutually exclusive (at most +1).
//  Reset mid-operation: partial frame, in-flight tags and FIFO contents are discarded. No result is emitted for them.
// TESTING
//  1. Reset, 8 beats 0x..00..0x..07 with s_last on beat 7, m_ready=1
//     -> net_in=concat(beat7..beat0); m_valid=1 exactly 5 cycles later, m_data=net_out at sample.
//  2. 20 frames back-to-back, m_ready=1 -> 20 results in order, s_ready never low, err_cnt=0.
//  3. m_ready=0, send 10 frames -> 8 results queued, occupancy=8, s_ready=0 on frame 9's final beat;
//     then raise m_ready -> frames 9,10 complete, all 10 in order.
//  4. s_last on beat 3 -> err_cnt=1, no result; next well-formed frame yields exactly one result.
//  5. 11 beats with s_last on beat 10 -> err_cnt=1, no result, beats 8..10 dropped; next frame correct.
//  6. Assert rst with 3 frames in flight and 2 queued -> after reset m_valid=0, occupancy=0, err_cnt=0;
//     no stale results appear.

Source files
------------

// File: rtl/logicnet_stream_shell.sv
// Streaming shell around a fixed-latency pipelined LogicNet: beat assembly, in-flight tag tracking,
// credit-limited issue and a first-word fall-through result FIFO.
module logicnet_stream_shell #(
    parameter int BEAT_W     = 64,
    parameter int IN_W       = 512,
    parameter int OUT_W      = 2,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ERRC_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [BEAT_W-1:0]             s_data,
    input  logic                          s_last,
    output logic [IN_W-1:0]               net_in,
    input  logic [OUT_W-1:0]              net_out,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [OUT_W-1:0]              m_data,
    output logic [ERRC_W-1:0]             err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);
    localparam int BEATS = IN_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int OCC_W = AW + 1;

    localparam logic [0:0]       ST_FILL   = 1'b0;
    localparam logic [0:0]       ST_DROP   = 1'b1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IN_W-1:0]   net_in_q, net_in_d;
    logic [LATENCY:0]  tag_q, tag_d;
    logic [OUT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [ERRC_W-1:0] err_q, err_d;

    logic final_slot_s, s_ready_s, accept_s, fifo_empty_s, fifo_full_s;
    logic m_valid_s, pop_s, push_s, issue_s, err_inc_s;

    // Credit stall applies only to the beat that would issue; a same-cycle pop is not counted.
    assign final_slot_s = (beat_cnt_q == LAST_SLOT);
    assign s_ready_s    = !rst && ((state_q == ST_DROP) || !(final_slot_s && (occ_q >= OCC_FULL)));
    assign accept_s     = s_valid && s_ready_s;
    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign m_valid_s    = !rst && !fifo_empty_s;
    assign pop_s        = m_valid_s && m_ready;
    assign push_s       = tag_q[LATENCY];

    // Frame assembly FSM: slot writes, short/long frame detection and issue.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        net_in_d   = net_in_q;
        issue_s    = 1'b0;
        err_inc_s  = 1'b0;
        if (accept_s) begin
            case (state_q)
                ST_FILL: begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (beat_cnt_q == CNT_W'(k)) begin
                            net_in_d[k*BEAT_W +: BEAT_W] = s_data;
                        end else begin
                            net_in_d[k*BEAT_W +: BEAT_W] = net_in_q[k*BEAT_W +: BEAT_W];
                        end
                    end
                    if (!final_slot_s) begin
                        if (s_last) begin
                            err_inc_s  = 1'b1;
                            beat_cnt_d = {CNT_W{1'b0}};
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        beat_cnt_d = {CNT_W{1'b0}};
                        if (s_last) begin
                            issue_s = 1'b1;
                        end else begin
                            err_inc_s = 1'b1;
                            state_d   = ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_last) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Tag pipeline, FIFO pointers, occupancy and saturating error count.
    always_comb begin
        tag_d    = {tag_q[LATENCY-1:0], issue_s};
        wr_ptr_d = push_s ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
        if (issue_s && !pop_s) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!issue_s && pop_s) begin
            occ_d = occ_q - OCC_W'(1);
        end else begin
            occ_d = occ_q;
        end
        if (err_inc_s && (err_q != {ERRC_W{1'b1}})) begin
            err_d = err_q + ERRC_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FILL;
            beat_cnt_q <= {CNT_W{1'b0}};
            net_in_q   <= {IN_W{1'b0}};
            tag_q      <= {(LATENCY+1){1'b0}};
            wr_ptr_q   <= {(AW+1){1'b0}};
            rd_ptr_q   <= {(AW+1){1'b0}};
            occ_q      <= {OCC_W{1'b0}};
            err_q      <= {ERRC_W{1'b0}};
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            net_in_q   <= net_in_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            err_q      <= err_d;
        end
    end

    // Result storage; contents are meaningless outside the pointer window.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= net_out;
        end
    end

    assign s_ready   = s_ready_s;
    assign m_valid   = m_valid_s;
    assign m_data    = mem_q[rd_ptr_q[AW-1:0]];
    assign net_in    = net_in_q;
    assign err_cnt   = err_q;
    assign occupancy = occ_q;

    logicnet_stream_shell_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_s),
        .full_i (fifo_full_s)
    );
endmodule

// Guard that the credit scheme keeps the result FIFO from being written while full.
module logicnet_stream_shell_chk (
    input logic clk,
    input logic rst,
    input logic push_i,
    input logic full_i
);
    // Flags a write into a full FIFO.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push_i && full_i));
        end
    end
endmodule
